serializer_8_bit: RTL and testbench
===================================

SERIALIZER_8_BIT -- requirements
Module: serializer_8_bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter: MSB_FIRST, default 1, meaning 1 = transmit bit 7 first, 0 = transmit bit 0 first.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: D_in_p  input  8  parallel byte to transmit, sampled only on an accept.
REQ-006 Port: load_valid  input  1  producer offers D_in_p this cycle.
REQ-007 Port: load_ready  output  1  block can accept a byte this cycle.
REQ-008 Port: D_out_s  output  1  serial data bit, registered.
REQ-009 Port: bit_valid  output  1  D_out_s carries a valid frame bit this cycle.
REQ-010 Port: last_bit  output  1  current D_out_s is the 8th bit of the frame.

Function
REQ-011 Accept SHALL occur at a rising edge where load_valid=1 and load_ready=1 and reset=0; D_in_p SHALL be captured into an 8-bit shift register only on accept.
REQ-012 State machine SHALL have two states: IDLE and SHIFT, with a 3-bit bit counter (0..7).
REQ-013 IDLE: load_ready=1, bit_valid=0, last_bit=0, D_out_s=0; on accept -> SHIFT, counter=0.
REQ-014 SHIFT: bit_valid=1; D_out_s = shift register bit 7 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0); each edge shifts by one and increments the counter.
REQ-015 Latency: bit 0 of the frame SHALL appear on D_out_s in the cycle immediately after the accept edge; the frame SHALL occupy exactly 8 consecutive bit_valid cycles.
REQ-016 last_bit SHALL be 1 exactly when state=SHIFT and counter=7.
REQ-017 load_ready SHALL be combinational: 1 in IDLE or when last_bit=1, 0 otherwise.
REQ-018 Back-to-back: accept while last_bit=1 SHALL reload the register, reset the counter to 0 and remain in SHIFT, so the next frame starts with no idle cycle.
REQ-019 At counter=7 with no accept, the next state SHALL be IDLE.
REQ-020 load_valid while load_ready=0 SHALL be ignored; the in-flight frame and D_in_p sampling are unaffected.
REQ-021 With MSB_FIRST=1, an 8-bit serial-in shift register clocked on clk that shifts in D_out_s toward bit 7 while bit_valid=1 SHALL hold the original byte after the 8th bit.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, counter=0, shift register=0x00; outputs SHALL then be load_ready=1, D_out_s=0, bit_valid=0, last_bit=0.
REQ-023 Reset mid-frame SHALL discard the partial frame with no further bit_valid cycles.
REQ-024 Reset SHALL take priority over a simultaneous accept; no byte is captured on that edge.

Structure
REQ-025 State encodings (IDLE, SHIFT), the frame width constant (8) and the last-bit count (7) SHALL live in the shared include-guarded constants header used by the shift-register family.
REQ-026 The bit counter SHALL be a single sub-module, bit_counter_3 (3-bit, sync active-high clear, enable, terminal-count output).

Verification
REQ-027 Reset, then accept 0xA5 (MSB_FIRST=1) -> D_out_s = 1,0,1,0,0,1,0,1 over 8 cycles, bit_valid high 8 cycles, last_bit only on the 8th; a downstream 8-bit SIPO holds 0xA5.
REQ-028 load_valid held with 0x3C then 0xC3, second accepted at last_bit -> 16 contiguous bit_valid cycles, serial 00111100 11000011, then IDLE.
REQ-029 Mid-frame at counter 3, present load_valid=1, D_in_p=0xFF -> load_ready=0, no capture, frame bits unchanged.
REQ-030 Reset asserted during the 5th bit -> next cycle bit_valid=0, D_out_s=0, load_ready=1; no remaining bits emitted.
REQ-031 MSB_FIRST=0, accept 0x01 -> D_out_s = 1 then seven 0s.
REQ-032 reset=1 and load_valid=1 with 0x77 on the same edge -> no accept, block stays IDLE, bit_valid stays 0.

Source files
------------

// File: rtl/serializer_8_bit_pkg.sv
// serializer_8_bit_pkg: shared state encodings and frame constants for the shift-register family
`ifndef SERIALIZER_8_BIT_PKG_SV
`define SERIALIZER_8_BIT_PKG_SV
package serializer_8_bit_pkg;
  localparam int FRAME_W = 8;
  localparam logic [2:0] LAST_CNT = 3'd7;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage
`endif

// File: rtl/serializer_8_bit_counter.sv
// bit_counter_3: 3-bit frame bit counter with sync clear, enable and terminal count
module bit_counter_3
  import serializer_8_bit_pkg::*;
(
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [2:0] r_count;
  always_ff @(posedge clk)
    r_count <= i_clr ? 3'd0 : i_en ? r_count + 3'd1 : r_count;
  assign o_tc = r_count == LAST_CNT;
endmodule

// File: rtl/serializer_8_bit.sv
// serializer_8_bit: byte-to-serial converter with valid/ready load and back-to-back frames
module serializer_8_bit
  import serializer_8_bit_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] D_in_p,
  input  logic               load_valid,
  output logic               load_ready,
  output logic               D_out_s,
  output logic               bit_valid,
  output logic               last_bit
);
  state_t r_state, w_next;
  logic [FRAME_W-1:0] r_sr;
  logic w_tc, w_accept;
  bit_counter_3 u_cnt (
    .clk  (clk),
    .i_clr(reset | w_accept),
    .i_en (r_state == SHIFT),
    .o_tc (w_tc)
  );
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk)
    r_sr <= reset ? '0 : w_accept ? D_in_p : r_state != SHIFT ? r_sr :
            MSB_FIRST ? {r_sr[FRAME_W-2:0], 1'b0} : {1'b0, r_sr[FRAME_W-1:1]};
  // accepting on the last bit reloads without leaving SHIFT, so frames abut
  always_comb begin
    bit_valid  = r_state == SHIFT;
    last_bit   = bit_valid && w_tc;
    load_ready = !bit_valid || last_bit;
    w_accept   = load_valid && load_ready;
    D_out_s    = bit_valid && (MSB_FIRST ? r_sr[FRAME_W-1] : r_sr[0]);
    w_next     = w_accept ? SHIFT : last_bit ? IDLE : r_state;
  end
endmodule

// File: tb/tb_serializer_8_bit.sv
// tb_serializer_8_bit: table vectors, corner sequences and random traffic against a bit-index model
module tb_serializer_8_bit;
  logic clk, reset, load_valid;
  logic [7:0] D_in_p;
  logic load_ready, D_out_s, bit_valid, last_bit;
  logic lr_l, do_l, bv_l, lb_l;
  int checks, errors, nv;
  logic [15:0] col_m, col_l;
  logic m_act;
  int m_pos;
  logic [7:0] m_cur, rb;

  serializer_8_bit #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .D_in_p(D_in_p), .load_valid(load_valid),
    .load_ready(load_ready), .D_out_s(D_out_s), .bit_valid(bit_valid), .last_bit(last_bit));
  serializer_8_bit #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .D_in_p(D_in_p), .load_valid(load_valid),
    .load_ready(lr_l), .D_out_s(do_l), .bit_valid(bv_l), .last_bit(lb_l));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // model: current byte plus index of the bit on the wire; frame is bits 0..7 of that index
  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    logic ev, el, er, ebm, ebl;
    reset = r; load_valid = v; D_in_p = d;
    #1;
    ev  = m_act;
    el  = m_act && m_pos == 7;
    er  = !m_act || el;
    ebm = ev && m_cur[7 - m_pos];
    ebl = ev && m_cur[m_pos];
    chk("valid", bit_valid, ev);
    chk("last", last_bit, el);
    chk("ready", load_ready, er);
    chk("dout_msb", D_out_s, ebm);
    chk("lsb_outs", {bv_l, lb_l, lr_l, do_l}, {ev, el, er, ebl});
    if (bit_valid) begin col_m = {col_m[14:0], D_out_s}; nv++; end
    if (bv_l) col_l = {col_l[14:0], do_l};
    if (r) m_act = 0;
    else if (v && er) begin m_cur = d; m_pos = 0; m_act = 1; end
    else if (m_act) begin
      m_pos++;
      if (m_pos == 8) m_act = 0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic r, v;
    logic [7:0] d;
    logic ev, el, er, eb;
  } vec_t;
  vec_t tv[11];

  initial begin
    checks = 0; errors = 0; nv = 0; col_m = 0; col_l = 0;
    m_act = 0; m_pos = 0; m_cur = 0;
    reset = 1; load_valid = 0; D_in_p = 0;
    repeat (2) @(negedge clk);
    tv[0]  = '{0, 1, 8'hA5, 0, 0, 1, 0};
    tv[1]  = '{0, 0, 8'h00, 1, 0, 0, 1};
    tv[2]  = '{0, 0, 8'h00, 1, 0, 0, 0};
    tv[3]  = '{0, 0, 8'h00, 1, 0, 0, 1};
    tv[4]  = '{0, 0, 8'h00, 1, 0, 0, 0};
    tv[5]  = '{0, 0, 8'h00, 1, 0, 0, 0};
    tv[6]  = '{0, 0, 8'h00, 1, 0, 0, 1};
    tv[7]  = '{0, 0, 8'h00, 1, 0, 0, 0};
    tv[8]  = '{0, 0, 8'h00, 1, 1, 1, 1};
    tv[9]  = '{1, 1, 8'h77, 0, 0, 1, 0};
    tv[10] = '{0, 0, 8'h00, 0, 0, 1, 0};
    for (int i = 0; i < 11; i++) begin
      reset = tv[i].r; load_valid = tv[i].v; D_in_p = tv[i].d;
      #1;
      chk($sformatf("tv%0d", i), {bit_valid, last_bit, load_ready, D_out_s},
          {tv[i].ev, tv[i].el, tv[i].er, tv[i].eb});
      cyc(tv[i].r, tv[i].v, tv[i].d);
    end
    chk("a5_sipo", col_m[7:0], 8'hA5);
    chk("a5_len", nv, 8);

    col_m = 0; nv = 0;
    repeat (8) cyc(0, 1, 8'h3C);
    cyc(0, 1, 8'hC3);
    repeat (9) cyc(0, 0, 8'h00);
    chk("b2b_bits", col_m, 16'h3CC3);
    chk("b2b_len", nv, 16);

    rb = 8'($urandom);
    cyc(0, 1, rb);
    repeat (3) cyc(0, 0, 8'h00);
    cyc(0, 1, 8'hFF);
    repeat (5) cyc(0, 0, 8'h00);
    chk("ignore_bits", col_m[7:0], rb);

    nv = 0;
    cyc(0, 1, 8'($urandom));
    repeat (4) cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h00);
    repeat (3) cyc(0, 0, 8'h00);
    chk("midrst_len", nv, 5);

    col_l = 0; col_m = 0;
    cyc(0, 1, 8'h01);
    repeat (9) cyc(0, 0, 8'h00);
    chk("lsb_01", col_l[7:0], 8'h80);
    chk("msb_01", col_m[7:0], 8'h01);

    repeat (300) cyc($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
